bsg_fsb_ring_tap: RTL and testbench



---
 rtl/bsg_fsb_pkg.sv | 34 +++
 rtl/bsg_fsb_two_fifo.sv | 56 +++++
 rtl/bsg_fsb_ring_tap.sv | 110 +++++++++++
 tb/tb_bsg_fsb_ring_tap.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_fsb_pkg.sv
// Shared FSB ring definitions: destination classes, per-head routing
// states and helpers for the destination-ID field.
package bsg_fsb_pkg;

  typedef enum logic [1:0] {
    FSB_LOCAL,
    FSB_RING,
    FSB_BCAST
  } fsb_dest_e;

  // Broadcast head progress; encodes which sides have already taken the head.
  typedef enum logic [1:0] {
    WAIT_BOTH  = 2'b00,
    WAIT_LOCAL = 2'b01,  // ring side done
    WAIT_RING  = 2'b10   // local side done
  } fsb_tap_state_e;

  // All-ones ID of the given width.
  function automatic logic [31:0] fsb_bcast_id(input int unsigned id_width);
    logic [63:0] one_hot;
    one_hot = 64'd1 << id_width;
    return 32'(one_hot - 64'd1);
  endfunction

  // Destination ID = the id_width MSBs of a width-bit packet.
  function automatic logic [31:0] fsb_dest_id(input logic [127:0] pkt,
                                              input int unsigned width,
                                              input int unsigned id_width);
    logic [127:0] shifted;
    shifted = pkt >> (width - id_width);
    return shifted[31:0] & fsb_bcast_id(id_width);
  endfunction

endpackage

// File: rtl/bsg_fsb_two_fifo.sv
// Two-entry ready/valid FIFO, no bypass; ready_o is ~full (forced low in reset).
module bsg_fsb_two_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               full_q, full_d;
  logic               enq, deq;

  assign ready_o = reset_n_i & ~full_q;
  assign v_o     = full_q | (rd_q != wr_q);
  assign data_o  = mem_q[rd_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointer and full-flag next state.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    full_d = full_q;
    if (enq) wr_d = ~wr_q;
    if (deq) rd_d = ~rd_q;
    if (enq && !deq)      full_d = (wr_d == rd_q);
    else if (deq && !enq) full_d = 1'b0;
  end

  // Pointer/flag registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      full_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      full_q <= full_d;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_fsb_ring_tap.sv
// FSB ring stop: routes FIFO head to local gateway, next hop, or both (broadcast).
// Optional macro BSG_FSB_RING_TAP_STATS_EN adds saturating handshake counters.
module bsg_fsb_ring_tap
  import bsg_fsb_pkg::*;
#(
  parameter int width_p    = 16,
  parameter int id_width_p = 5,
  parameter int id_p       = 5
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               ring_v_o,
  output logic [width_p-1:0] ring_data_o,
  input  logic               ring_ready_i,
  output logic               local_v_o,
  output logic [width_p-1:0] local_data_o,
`ifdef BSG_FSB_RING_TAP_STATS_EN
  output logic [15:0]        local_cnt_o,
  output logic [15:0]        fwd_cnt_o,
`endif
  input  logic               local_yumi_i
);

  logic [width_p-1:0] head;
  logic               head_v;
  logic               head_yumi;
  logic [31:0]        dest_id;
  fsb_dest_e          dest_cls;
  fsb_tap_state_e     state_q, state_d;
  logic               ring_sent, local_sent;
  logic               ring_hs, local_hs;

  bsg_fsb_two_fifo #(.width_p(width_p)) fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (head_v),
    .data_o   (head),
    .yumi_i   (head_yumi)
  );

  assign dest_id      = fsb_dest_id(128'(head), width_p, id_width_p);
  assign ring_sent    = (state_q == WAIT_LOCAL);
  assign local_sent   = (state_q == WAIT_RING);
  assign ring_data_o  = head;
  assign local_data_o = head;

  // Classify head, drive valids, decide dequeue and broadcast progress.
  always_comb begin
    dest_cls  = FSB_RING;
    ring_v_o  = 1'b0;
    local_v_o = 1'b0;
    ring_hs   = 1'b0;
    local_hs  = 1'b0;
    head_yumi = 1'b0;
    state_d   = state_q;

    if (dest_id == 32'(id_p))                 dest_cls = FSB_LOCAL;
    else if (dest_id == fsb_bcast_id(id_width_p)) dest_cls = FSB_BCAST;

    ring_v_o  = head_v & ((dest_cls == FSB_RING)  | ((dest_cls == FSB_BCAST) & ~ring_sent));
    local_v_o = head_v & ((dest_cls == FSB_LOCAL) | ((dest_cls == FSB_BCAST) & ~local_sent));
    ring_hs   = ring_v_o & ring_ready_i;
    local_hs  = local_v_o & local_yumi_i;

    unique case (dest_cls)
      FSB_LOCAL: head_yumi = local_hs;
      FSB_RING:  head_yumi = ring_hs;
      default:   head_yumi = (ring_sent | ring_hs) & (local_sent | local_hs);
    endcase

    if (head_yumi)     state_d = WAIT_BOTH;
    else if (ring_hs)  state_d = WAIT_LOCAL;
    else if (local_hs) state_d = WAIT_RING;
  end

  // Broadcast progress register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= WAIT_BOTH;
    else            state_q <= state_d;
  end

`ifdef BSG_FSB_RING_TAP_STATS_EN
  logic [15:0] local_cnt_q, fwd_cnt_q;

  // Saturating handshake counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      local_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (local_hs && local_cnt_q != '1) local_cnt_q <= local_cnt_q + 16'd1;
      if (ring_hs  && fwd_cnt_q   != '1) fwd_cnt_q   <= fwd_cnt_q + 16'd1;
    end
  end

  assign local_cnt_o = local_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

  // The gateway must only consume a presented head.
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    local_yumi_i |-> local_v_o);

endmodule

// File: tb/tb_bsg_fsb_ring_tap.sv
// Directed bench for bsg_fsb_ring_tap. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_bsg_fsb_ring_tap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        ready_o;
  logic        ring_v_o;
  logic [15:0] ring_data_o;
  logic        ring_ready_i = 1'b0;
  logic        local_v_o;
  logic [15:0] local_data_o;
  logic        local_yumi_i = 1'b0;
`ifdef BSG_FSB_RING_TAP_STATS_EN
  logic [15:0] local_cnt_o;
  logic [15:0] fwd_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_fsb_ring_tap #(.width_p(16), .id_width_p(5), .id_p(5)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .v_i         (v_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .ring_v_o    (ring_v_o),
    .ring_data_o (ring_data_o),
    .ring_ready_i(ring_ready_i),
    .local_v_o   (local_v_o),
    .local_data_o(local_data_o),
`ifdef BSG_FSB_RING_TAP_STATS_EN
    .local_cnt_o (local_cnt_o),
    .fwd_cnt_o   (fwd_cnt_o),
`endif
    .local_yumi_i(local_yumi_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    checks++; if ({ring_v_o, local_v_o} !== 2'b00) begin errors++; $display("FAIL reset_valids got=%b exp=00", {ring_v_o, local_v_o}); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", ready_o); end
    tick(); tick();
    checks++; if ({ring_v_o, local_v_o} !== 2'b00) begin errors++; $display("FAIL idle_valids got=%b exp=00", {ring_v_o, local_v_o}); end
    // Mid-cycle reset with a packet resident.
    v_i = 1'b1; data_i = 16'h1234;
    tick();
    v_i = 1'b0;
    checks++; if (ring_v_o !== 1'b1) begin errors++; $display("FAIL prereset_ringv got=%b exp=1", ring_v_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ready_o, ring_v_o, local_v_o} !== 3'b000) begin errors++; $display("FAIL midreset_outs got=%b exp=000", {ready_o, ring_v_o, local_v_o}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({ready_o, ring_v_o, local_v_o} !== 3'b100) begin errors++; $display("FAIL postreset_outs got=%b exp=100", {ready_o, ring_v_o, local_v_o}); end
  endtask

  task automatic test_local();
    ring_ready_i = 1'b1;
    v_i = 1'b1; data_i = 16'h2AAA;
    tick();
    v_i = 1'b0;
    checks++; if (local_v_o !== 1'b1 || local_data_o !== 16'h2AAA) begin errors++; $display("FAIL local_present got=%b/%h exp=1/2aaa", local_v_o, local_data_o); end
    checks++; if (ring_v_o !== 1'b0) begin errors++; $display("FAIL local_ringv got=%b exp=0", ring_v_o); end
    local_yumi_i = 1'b1;
    tick();
    local_yumi_i = 1'b0;
    checks++; if ({local_v_o, ring_v_o, ready_o} !== 3'b001) begin errors++; $display("FAIL local_drain got=%b exp=001", {local_v_o, ring_v_o, ready_o}); end
    ring_ready_i = 1'b0;
  endtask

  task automatic test_forward();
    int xfers = 0;
    ring_ready_i = 1'b0;
    v_i = 1'b1; data_i = 16'h1234;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ring_ready_i = 1'b1;
      checks++; if (ring_v_o !== 1'b1 || ring_data_o !== 16'h1234 || local_v_o !== 1'b0) begin
        errors++; $display("FAIL fwd_hold_%0d got=%b/%h/%b exp=1/1234/0", i, ring_v_o, ring_data_o, local_v_o);
      end
      if (ring_v_o && ring_ready_i) xfers++;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      if (ring_v_o && ring_ready_i) xfers++;
      tick();
    end
    ring_ready_i = 1'b0;
    checks++; if (xfers != 1) begin errors++; $display("FAIL fwd_xfers got=%0d exp=1", xfers); end
  endtask

  task automatic test_full();
    ring_ready_i = 1'b0;
    v_i = 1'b1; data_i = 16'h1234;
    tick();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_ready1 got=%b exp=1", ready_o); end
    data_i = 16'h1235;
    tick();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready2 got=%b exp=0", ready_o); end
    data_i = 16'h1236;
    tick();
    checks++; if (ready_o !== 1'b0 || ring_data_o !== 16'h1234) begin errors++; $display("FAIL full_hold got=%b/%h exp=0/1234", ready_o, ring_data_o); end
    ring_ready_i = 1'b1;
    tick();
    checks++; if (ready_o !== 1'b1 || ring_data_o !== 16'h1235) begin errors++; $display("FAIL full_order2 got=%b/%h exp=1/1235", ready_o, ring_data_o); end
    tick();
    v_i = 1'b0;
    checks++; if (ring_v_o !== 1'b1 || ring_data_o !== 16'h1236) begin errors++; $display("FAIL full_order3 got=%b/%h exp=1/1236", ring_v_o, ring_data_o); end
    tick();
    checks++; if (ring_v_o !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", ring_v_o); end
    ring_ready_i = 1'b0;
  endtask

  task automatic test_bcast_split();
    reset_dut();
    v_i = 1'b1; data_i = 16'hF800;
    tick();
    v_i = 1'b0;
    checks++; if ({ring_v_o, local_v_o} !== 2'b11 || ring_data_o !== 16'hF800) begin errors++; $display("FAIL bc_c1 got=%b/%h exp=11/f800", {ring_v_o, local_v_o}, ring_data_o); end
    ring_ready_i = 1'b1;
    tick();
    ring_ready_i = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      checks++; if ({ring_v_o, local_v_o} !== 2'b01) begin errors++; $display("FAIL bc_c%0d got=%b exp=01", c, {ring_v_o, local_v_o}); end
      if (c == 4) local_yumi_i = 1'b1;
      if (c < 4) tick();
    end
    tick();
    local_yumi_i = 1'b0;
    checks++; if ({ring_v_o, local_v_o, ready_o} !== 3'b001) begin errors++; $display("FAIL bc_done got=%b exp=001", {ring_v_o, local_v_o, ready_o}); end
`ifdef BSG_FSB_RING_TAP_STATS_EN
    checks++; if (local_cnt_o !== 16'd1 || fwd_cnt_o !== 16'd1) begin errors++; $display("FAIL bc_stats got=%0d/%0d exp=1/1", local_cnt_o, fwd_cnt_o); end
`endif
  endtask

  task automatic test_bcast_simul();
    ring_ready_i = 1'b1;
    v_i = 1'b1; data_i = 16'hF801;
    tick();
    data_i = 16'h2AAA;
    local_yumi_i = 1'b1;
    checks++; if ({ring_v_o, local_v_o} !== 2'b11 || local_data_o !== 16'hF801) begin errors++; $display("FAIL sim_present got=%b/%h exp=11/f801", {ring_v_o, local_v_o}, local_data_o); end
    tick();
    v_i = 1'b0;
    local_yumi_i = 1'b0;
    checks++; if ({ring_v_o, local_v_o} !== 2'b01 || local_data_o !== 16'h2AAA) begin errors++; $display("FAIL sim_next got=%b/%h exp=01/2aaa", {ring_v_o, local_v_o}, local_data_o); end
`ifdef BSG_FSB_RING_TAP_STATS_EN
    checks++; if (local_cnt_o !== 16'd2 || fwd_cnt_o !== 16'd2) begin errors++; $display("FAIL sim_stats got=%0d/%0d exp=2/2", local_cnt_o, fwd_cnt_o); end
`endif
    local_yumi_i = 1'b1;
    tick();
    local_yumi_i = 1'b0;
    ring_ready_i = 1'b0;
    checks++; if ({ring_v_o, local_v_o, ready_o} !== 3'b001) begin errors++; $display("FAIL sim_empty got=%b exp=001", {ring_v_o, local_v_o, ready_o}); end
  endtask

  initial begin
    test_reset();
    test_local();
    test_forward();
    test_full();
    test_bcast_split();
    test_bcast_simul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
